fpro_mcs_bridge_multi: RTL and testbench



---
 rtl/fpro_brg_pkg.sv | 26 ++
 rtl/fpro_brg_decode.sv | 29 ++
 rtl/fpro_mcs_bridge_multi.sv | 201 ++++++++++++++++++++
 tb/tb_fpro_mcs_bridge_multi.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpro_brg_pkg.sv
// fpro_brg_pkg -- shared definitions for the multi-slot MCS-to-FPro bridge.
//   brg_state_t  : bridge transaction FSM states
//   DEF_BRG_BASE : default bridge base address (upper byte is decoded)
//   DEF_ERR_DATA : default read data returned when a slave times out
//   slot_index() : extracts the slot number from a MCS byte address
package fpro_brg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } brg_state_t;

  localparam logic [31:0] DEF_BRG_BASE = 32'hc000_0000;
  localparam logic [31:0] DEF_ERR_DATA = 32'hdead_beef;

  // Slot number lives in the top slot_bits bits of io_address[23:0].
  function automatic int unsigned slot_index(input logic [31:0] addr,
                                             input int          slot_bits);
    logic [23:0] low;
    low = addr[23:0] >> (24 - slot_bits);
    return {8'd0, low};
  endfunction

endpackage

// File: rtl/fpro_brg_decode.sv
// fpro_brg_decode -- combinational address decode for the multi-slot bridge.
//   addr      in   MCS byte address
//   in_range  out  addr[31:24] matches BRG_BASE[31:24]
//   slot      out  slot number from addr[23:24-SLOT_BITS]
//   cs        out  one-hot slot select, all zero when out of range
//   word_addr out  word address inside the slot, addr[23-SLOT_BITS:2]
module fpro_brg_decode
  import fpro_brg_pkg::*;
#(
  parameter logic [31:0] BRG_BASE  = DEF_BRG_BASE,
  parameter int          SLOT_BITS = 1,
  localparam int         N_SLOT    = 2**SLOT_BITS
) (
  input  logic [31:0]          addr,
  output logic                 in_range,
  output logic [SLOT_BITS-1:0] slot,
  output logic [N_SLOT-1:0]    cs,
  output logic [21-SLOT_BITS:0] word_addr
);

  always_comb begin
    in_range  = (addr[31:24] == BRG_BASE[31:24]);
    slot      = SLOT_BITS'(slot_index(addr, SLOT_BITS));
    cs        = '0;
    if (in_range) cs[slot] = 1'b1;
    word_addr = addr[23-SLOT_BITS:2];
  end

endmodule

// File: rtl/fpro_mcs_bridge_multi.sv
// fpro_mcs_bridge_multi -- MicroBlaze MCS IO bus to N_SLOT FPro slots with
// per-slot acks, bounded wait and a sticky timeout report.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   io_addr_strobe             MCS address strobe (not used)
//   io_read_strobe/write_strobe 1-cycle MCS requests (both high = write)
//   io_byte_enable, io_address, io_write_data   MCS request fields
//   io_read_data, io_ready     response; data valid only while io_ready=1
//   fp_cs, fp_wr, fp_rd        one-cycle slot select and direction pulses
//   fp_addr, fp_byte_en, fp_wr_data   request fields latched at acceptance
//   fp_rd_data, fp_ack         per-slot read data and completion
//   err_flag, err_addr, err_clr sticky timeout flag, first failing address
//
// Build option: define BRIDGE_WR_POST_EN to post writes (io_ready during
// ISSUE; a read arriving meanwhile is held and issued after the write ends).
module fpro_mcs_bridge_multi
  import fpro_brg_pkg::*;
#(
  parameter logic [31:0] BRG_BASE  = DEF_BRG_BASE,
  parameter int          SLOT_BITS = 1,
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] ERR_DATA  = DEF_ERR_DATA,
  localparam int         N_SLOT    = 2**SLOT_BITS
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       io_addr_strobe,
  input  logic                       io_read_strobe,
  input  logic                       io_write_strobe,
  input  logic [3:0]                 io_byte_enable,
  input  logic [31:0]                io_address,
  input  logic [31:0]                io_write_data,
  output logic [31:0]                io_read_data,
  output logic                       io_ready,
  output logic [N_SLOT-1:0]          fp_cs,
  output logic                       fp_wr,
  output logic                       fp_rd,
  output logic [21-SLOT_BITS:0]      fp_addr,
  output logic [3:0]                 fp_byte_en,
  output logic [31:0]                fp_wr_data,
  input  logic [N_SLOT-1:0][31:0]    fp_rd_data,
  input  logic [N_SLOT-1:0]          fp_ack,
  output logic                       err_flag,
  output logic [31:0]                err_addr,
  input  logic                       err_clr
);

  brg_state_t state, state_nxt;

  logic [31:0]          addr_p1;
  logic                 wr_p1;
  logic                 post_p1;
  logic [SLOT_BITS-1:0] slot_p1;
  logic [N_SLOT-1:0]    cs_p1;
  logic [15:0]          tmo_cnt;
  logic [31:0]          rdata_p2;

  logic                 start;
  logic                 start_wr;
  logic [31:0]          start_addr;
  logic [3:0]           start_be;

  logic                 dec_in_range;
  logic [SLOT_BITS-1:0] dec_slot;
  logic [N_SLOT-1:0]    dec_cs;
  logic [21-SLOT_BITS:0] dec_word;

  logic                 ack_sel;
  logic                 tmo_hit;

  logic                 unused;
  assign unused = io_addr_strobe;

`ifdef BRIDGE_WR_POST_EN
  localparam bit WR_POST = 1'b1;

  logic        pend_vld;
  logic [31:0] pend_addr;
  logic [3:0]  pend_be;

  // A held read takes priority; the MCS cannot strobe again until it is served.
  always_comb begin
    start      = pend_vld | io_read_strobe | io_write_strobe;
    start_wr   = !pend_vld && io_write_strobe;
    start_addr = pend_vld ? pend_addr : io_address;
    start_be   = pend_vld ? pend_be : io_byte_enable;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_vld  <= 1'b0;
      pend_addr <= '0;
      pend_be   <= '0;
    end else if (state == IDLE) begin
      pend_vld  <= 1'b0;
    end else if (post_p1 && io_read_strobe && !pend_vld) begin
      pend_vld  <= 1'b1;
      pend_addr <= io_address;
      pend_be   <= io_byte_enable;
    end
  end
`else
  localparam bit WR_POST = 1'b0;

  always_comb begin
    start      = io_read_strobe | io_write_strobe;
    start_wr   = io_write_strobe;
    start_addr = io_address;
    start_be   = io_byte_enable;
  end
`endif

  fpro_brg_decode #(
    .BRG_BASE  (BRG_BASE),
    .SLOT_BITS (SLOT_BITS)
  ) u_decode (
    .addr      (start_addr),
    .in_range  (dec_in_range),
    .slot      (dec_slot),
    .cs        (dec_cs),
    .word_addr (dec_word)
  );

  // Only the selected slot's ack counts; others are masked by cs_p1.
  assign ack_sel = |(fp_ack & cs_p1);
  assign tmo_hit = (state == WAIT) && !ack_sel && (tmo_cnt == 16'(TIMEOUT));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = dec_in_range ? ISSUE : RESP;
      ISSUE:   state_nxt = ack_sel ? RESP : WAIT;
      WAIT:    if (ack_sel || tmo_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A posted write answers the MCS during ISSUE and stays silent in RESP.
  always_comb begin
    fp_cs        = (state == ISSUE) ? cs_p1 : '0;
    fp_wr        = (state == ISSUE) && wr_p1;
    fp_rd        = (state == ISSUE) && !wr_p1;
    io_ready     = ((state == RESP) && !post_p1) || ((state == ISSUE) && post_p1);
    io_read_data = io_ready ? rdata_p2 : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      addr_p1    <= '0;
      wr_p1      <= 1'b0;
      post_p1    <= 1'b0;
      slot_p1    <= '0;
      cs_p1      <= '0;
      tmo_cnt    <= '0;
      rdata_p2   <= '0;
      fp_addr    <= '0;
      fp_byte_en <= '0;
      fp_wr_data <= '0;
      err_flag   <= 1'b0;
      err_addr   <= '0;
    end else begin
      state <= state_nxt;

      // Stage p1: request accepted in IDLE, driven to the slot in ISSUE
      if (state == IDLE && start) begin
        addr_p1    <= start_addr;
        wr_p1      <= start_wr;
        post_p1    <= WR_POST && start_wr && dec_in_range;
        slot_p1    <= dec_slot;
        cs_p1      <= dec_cs;
        fp_addr    <= dec_word;
        fp_byte_en <= start_be;
        fp_wr_data <= io_write_data;
        rdata_p2   <= '0;
      end

      // tmo_cnt holds the number of WAIT cycles elapsed since ISSUE
      if (state == ISSUE)     tmo_cnt <= 16'd1;
      else if (state == WAIT) tmo_cnt <= tmo_cnt + 16'd1;

      // Stage p2: response captured on ack or timeout, presented in RESP
      if ((state == ISSUE || state == WAIT) && ack_sel && !wr_p1)
        rdata_p2 <= fp_rd_data[slot_p1];
      else if (tmo_hit)
        rdata_p2 <= ERR_DATA;

      // A new timeout beats a simultaneous clear.
      if (tmo_hit && (!err_flag || err_clr)) begin
        err_flag <= 1'b1;
        err_addr <= addr_p1;
      end else if (err_clr) begin
        err_flag <= 1'b0;
        err_addr <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fpro_mcs_bridge_multi.sv
// tb_fpro_mcs_bridge_multi -- scoreboard bench for fpro_mcs_bridge_multi
// (default build, SLOT_BITS=1, TIMEOUT=8). Directed accesses push expected
// read data into a queue; a forked monitor pops on every io_ready.
module tb_fpro_mcs_bridge_multi;

  localparam int SLOT_BITS = 1;
  localparam int N_SLOT    = 2;
  localparam int TMO       = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    reset;
  logic                    io_addr_strobe;
  logic                    io_read_strobe;
  logic                    io_write_strobe;
  logic [3:0]              io_byte_enable;
  logic [31:0]             io_address;
  logic [31:0]             io_write_data;
  logic [31:0]             io_read_data;
  logic                    io_ready;
  logic [N_SLOT-1:0]       fp_cs;
  logic                    fp_wr;
  logic                    fp_rd;
  logic [21-SLOT_BITS:0]   fp_addr;
  logic [3:0]              fp_byte_en;
  logic [31:0]             fp_wr_data;
  logic [N_SLOT-1:0][31:0] fp_rd_data;
  logic [N_SLOT-1:0]       fp_ack;
  logic                    err_flag;
  logic [31:0]             err_addr;
  logic                    err_clr;

  fpro_mcs_bridge_multi #(
    .SLOT_BITS (SLOT_BITS),
    .TIMEOUT   (TMO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .io_addr_strobe  (io_addr_strobe),
    .io_read_strobe  (io_read_strobe),
    .io_write_strobe (io_write_strobe),
    .io_byte_enable  (io_byte_enable),
    .io_address      (io_address),
    .io_write_data   (io_write_data),
    .io_read_data    (io_read_data),
    .io_ready        (io_ready),
    .fp_cs           (fp_cs),
    .fp_wr           (fp_wr),
    .fp_rd           (fp_rd),
    .fp_addr         (fp_addr),
    .fp_byte_en      (fp_byte_en),
    .fp_wr_data      (fp_wr_data),
    .fp_rd_data      (fp_rd_data),
    .fp_ack          (fp_ack),
    .err_flag        (err_flag),
    .err_addr        (err_addr),
    .err_clr         (err_clr)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  int          ack_mode = 0;   // 0: all acks high, 1: delayed ack, 2: never ack
  int          ack_dly  = 5;

  // Slave model: in delayed mode the selected slot acks ack_dly cycles after
  // fp_cs while the non-selected slots ack meanwhile (must be ignored).
  initial begin
    logic [N_SLOT-1:0] sel;
    int                cnt;
    sel    = '0;
    cnt    = 0;
    fp_ack = '0;
    forever begin
      @(posedge clk);
      #1;
      case (ack_mode)
        0: fp_ack = '1;
        2: fp_ack = '0;
        default: begin
          if (fp_cs != '0) begin
            sel    = fp_cs;
            cnt    = ack_dly;
            fp_ack = ~sel;
          end else if (cnt > 1) begin
            cnt--;
            fp_ack = ~sel;
          end else if (cnt == 1) begin
            cnt    = 0;
            fp_ack = sel;
          end else begin
            fp_ack = '0;
          end
        end
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!reset && io_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_ready: got io_ready=1 data %h, expected no response", io_read_data);
        end else begin
          e = exp_q.pop_front();
          chk("rd_data", io_read_data, e);
        end
      end
    end
  endtask

  // One MCS transaction; cycle 0 is the strobe cycle, lat counts cycles to io_ready.
  task automatic access(input string name, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [N_SLOT-1:0] exp_cs,
                        input logic [21-SLOT_BITS:0] exp_faddr,
                        input logic [31:0] exp_data, input int exp_lat);
    int lat;
    bit done;
    exp_q.push_back(exp_data);
    @(posedge clk);
    #1;
    io_read_strobe  = rd;
    io_write_strobe = wr;
    io_address      = addr;
    io_write_data   = wdata;
    io_byte_enable  = be;
    lat  = 0;
    done = 1'b0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) begin
        io_read_strobe  = 1'b0;
        io_write_strobe = 1'b0;
      end
      @(negedge clk);
      if (lat == 1) begin
        chk({name, "_cs"}, 32'(fp_cs), 32'(exp_cs));
        if (exp_cs != '0) begin
          chk({name, "_faddr"}, 32'(fp_addr), 32'(exp_faddr));
          chk({name, "_dir"}, {30'd0, fp_wr, fp_rd}, {30'd0, wr, rd & ~wr});
          if (wr) begin
            chk({name, "_wdata"}, fp_wr_data, wdata);
            chk({name, "_be"}, 32'(fp_byte_en), 32'(be));
          end
        end
      end else if (lat == 2) begin
        chk({name, "_cs_drop"}, 32'(fp_cs), 32'd0);
      end
      if (io_ready) done = 1'b1;
    end
    chk({name, "_latency"}, lat, exp_lat);
  endtask

  initial begin
    int bad;
    reset           = 1'b1;
    io_addr_strobe  = 1'b0;
    io_read_strobe  = 1'b0;
    io_write_strobe = 1'b0;
    io_byte_enable  = '0;
    io_address      = '0;
    io_write_data   = '0;
    err_clr         = 1'b0;
    fp_rd_data[0]   = 32'h1234_5678;
    fp_rd_data[1]   = 32'hcafe_0001;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_io_ready", 32'(io_ready), 32'd0);
    chk("rst_rdata", io_read_data, 32'd0);
    chk("rst_cs", 32'(fp_cs), 32'd0);
    chk("rst_wr_rd", {30'd0, fp_wr, fp_rd}, 32'd0);
    chk("rst_err_flag", 32'(err_flag), 32'd0);
    chk("rst_err_addr", err_addr, 32'd0);
    chk("rst_faddr", 32'(fp_addr), 32'd0);
    chk("rst_wdata", fp_wr_data, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    fork
      monitor();
    join_none

    ack_mode = 0;
    access("rd0_zw", 1'b1, 1'b0, 32'hc000_0010, 32'h0, 4'hf, 2'b01, 21'd4,
           32'h1234_5678, 2);
    access("rd1_zw", 1'b1, 1'b0, 32'hc080_0020, 32'h0, 4'hf, 2'b10, 21'd8,
           32'hcafe_0001, 2);

    ack_mode = 1;
    ack_dly  = 5;
    access("wr1_wait", 1'b0, 1'b1, 32'hc080_0008, 32'h0bad_f00d, 4'b0011, 2'b10,
           21'd2, 32'h0, 7);

    ack_mode = 0;
    access("both_strobes", 1'b1, 1'b1, 32'hc000_0004, 32'h5555_aaaa, 4'hf, 2'b01,
           21'd1, 32'h0, 2);
    access("out_of_range", 1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'hf, 2'b00, 21'd0,
           32'h0, 1);

    ack_mode = 2;
    access("tmo1", 1'b1, 1'b0, 32'hc000_0040, 32'h0, 4'hf, 2'b01, 21'h10,
           32'hdead_beef, 2 + TMO);
    chk("tmo1_err_flag", 32'(err_flag), 32'd1);
    chk("tmo1_err_addr", err_addr, 32'hc000_0040);
    access("tmo2", 1'b1, 1'b0, 32'hc080_0044, 32'h0, 4'hf, 2'b10, 21'h11,
           32'hdead_beef, 2 + TMO);
    chk("tmo2_err_flag", 32'(err_flag), 32'd1);
    chk("tmo2_err_addr_kept", err_addr, 32'hc000_0040);

    @(posedge clk);
    #1;
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    @(negedge clk);
    chk("clr_err_flag", 32'(err_flag), 32'd0);
    chk("clr_err_addr", err_addr, 32'd0);

    // Reset while the bridge is waiting on a slow slave.
    ack_mode = 1;
    ack_dly  = 20;
    @(posedge clk);
    #1;
    io_read_strobe = 1'b1;
    io_address     = 32'hc000_0010;
    @(posedge clk);
    #1;
    io_read_strobe = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fp_cs != '0 || io_ready) bad++;
    end
    chk("rst_abort_quiet", bad, 0);

    ack_mode = 0;
    repeat (2) @(posedge clk);
    access("after_abort", 1'b1, 1'b0, 32'hc000_0010, 32'h0, 4'hf, 2'b01, 21'd4,
           32'h1234_5678, 2);

    // Timeout with err_clr held high: the new error must win over the clear.
    ack_mode = 2;
    access("tmo3", 1'b1, 1'b0, 32'hc000_0080, 32'h0, 4'hf, 2'b01, 21'h20,
           32'hdead_beef, 2 + TMO);
    chk("tmo3_err_addr", err_addr, 32'hc000_0080);
    err_clr = 1'b1;
    access("tmo4_clr", 1'b1, 1'b0, 32'hc080_0084, 32'h0, 4'hf, 2'b10, 21'h21,
           32'hdead_beef, 2 + TMO);
    chk("set_wins_flag", 32'(err_flag), 32'd1);
    chk("set_wins_addr", err_addr, 32'hc080_0084);
    @(posedge clk);
    #1;
    err_clr  = 1'b0;
    ack_mode = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
